// File: rtl/tt_pkg.sv
// Shared constants, sweep state encoding and width typedefs for the
// truth-table capture block and its controller.
package tt_pkg;

  localparam int N_IN = 7;
  localparam int TT_W = 2 ** N_IN;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    CHECK,
    DONE
  } state_t;

  typedef logic [TT_W-1:0] tt_t;
  typedef logic [N_IN-1:0] minterm_t;
  typedef logic [N_IN:0]   count_t;

  // Start-cycle to done-cycle distance for a given settle setting.
  function automatic int sweep_cycles(input int settle);
    return TT_W * (settle + 1) + 2;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl.sv
// Sweep sequencer: walks the minterm index, inserts settle cycles and
// tells the datapath when to sample, when the table is complete and when to compare.
module tt_sweep_ctrl
  import tt_pkg::*;
#(
  parameter int IDX_W  = 7,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  output logic             o_accept,
  output logic             o_sample_en,
  output logic             o_last,
  output logic             o_check,
  output logic             o_busy,
  output logic             o_done,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_wait;
  logic             w_accept;
  logic             w_sample_en;
  logic             w_last;

  assign w_sample_en = (r_state == SWEEP) && (r_wait == SETTLE_V);
  assign w_last      = w_sample_en && (r_idx == {IDX_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = SWEEP;
          w_accept     = 1'b1;
        end
      end
      SWEEP: begin
        if (w_last) begin
          w_state_next = CHECK;
        end
      end
      CHECK:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The index stops on the last minterm so x_out keeps showing it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_wait <= '0;
    end else if (w_accept) begin
      r_idx  <= '0;
      r_wait <= '0;
    end else if (r_state == SWEEP) begin
      if (w_sample_en) begin
        r_wait <= '0;
        if (!w_last) begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  assign o_accept    = w_accept;
  assign o_sample_en = w_sample_en;
  assign o_last      = w_last;
  assign o_check     = (r_state == CHECK);
  assign o_busy      = (r_state == SWEEP) || (r_state == CHECK);
  assign o_done      = (r_state == DONE);
  assign o_idx       = r_idx;

endmodule

// File: rtl/tt_sweep_capture.sv
// Truth-table extractor: drives every minterm into an external combinational
// function, records its output per minterm, then compares and counts onsets.
module tt_sweep_capture #(
  parameter int N_IN   = tt_pkg::N_IN,
  parameter int SETTLE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2**N_IN-1:0] expected_tt,
  input  logic               f_in,
  output logic [N_IN-1:0]    x_out,
  output logic               busy,
  output logic               done,
  output logic [2**N_IN-1:0] tt_out,
  output logic               match,
  output logic [N_IN:0]      ones_count
);

  localparam int W_TT = 2 ** N_IN;

  logic            w_accept;
  logic            w_sample_en;
  logic            w_last;
  logic            w_check;
  logic [N_IN-1:0] w_idx;

  logic [W_TT-1:0] r_expected;
  logic [W_TT-1:0] r_tt;
  logic [N_IN:0]   r_ones;
  logic            r_match;

  tt_sweep_ctrl #(
    .IDX_W (N_IN),
    .SETTLE(SETTLE)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .o_accept   (w_accept),
    .o_sample_en(w_sample_en),
    .o_last     (w_last),
    .o_check    (w_check),
    .o_busy     (busy),
    .o_done     (done),
    .o_idx      (w_idx)
  );

  // f_in is only ever captured into registers, never routed to an output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_expected <= '0;
      r_tt       <= '0;
      r_ones     <= '0;
      r_match    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_expected <= expected_tt;
        r_tt       <= '0;
        r_ones     <= '0;
      end
      if (w_sample_en) begin
        r_tt[w_idx] <= f_in;
        r_ones      <= r_ones + (N_IN + 1)'(f_in);
      end
      if (w_check) begin
        r_match <= (r_tt == r_expected);
      end
    end
  end

  assign x_out      = w_idx;
  assign tt_out     = r_tt;
  assign ones_count = r_ones;
  assign match      = r_match;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: two instances (settle 0 and 3) driving a
// selectable reference function, checked every cycle against a timeline model.
module tb_tt_sweep_capture;
  import tt_pkg::*;

  localparam int S0 = 0;
  localparam int S1 = 3;

  logic     clk = 1'b0;
  always #5 clk = ~clk;

  logic     rst_s   [2];
  logic     start_s [2];
  tt_t      exp_s   [2];
  logic     f_in_s  [2];
  minterm_t x_s     [2];
  logic     busy_s  [2];
  logic     done_s  [2];
  tt_t      tt_s    [2];
  logic     match_s [2];
  count_t   ones_s  [2];

  int  fsel   [2];
  tt_t rnd_tt [2];

  int vectors     = 0;
  int miscompares = 0;

  tt_sweep_capture #(.N_IN(N_IN), .SETTLE(S0)) u0 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .expected_tt(exp_s[0]),
    .f_in(f_in_s[0]), .x_out(x_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .tt_out(tt_s[0]), .match(match_s[0]), .ones_count(ones_s[0])
  );

  tt_sweep_capture #(.N_IN(N_IN), .SETTLE(S1)) u1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .expected_tt(exp_s[1]),
    .f_in(f_in_s[1]), .x_out(x_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .tt_out(tt_s[1]), .match(match_s[1]), .ones_count(ones_s[1])
  );

  // Function library: 0 const0, 1 const1, 2 x0, 3 x6, 4 maj(x0,x1,x2), else lookup.
  function automatic logic fval(input int sel, input minterm_t x, input tt_t r);
    case (sel)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return x[0];
      3:       return x[6];
      4:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
      default: return r[x];
    endcase
  endfunction

  function automatic tt_t model_tt(input int sel, input tt_t r);
    tt_t t;
    for (int i = 0; i < TT_W; i++) t[i] = fval(sel, minterm_t'(i), r);
    return t;
  endfunction

  function automatic int settle_of(input int k);
    return (k == 0) ? S0 : S1;
  endfunction

  always_comb begin
    f_in_s[0] = fval(fsel[0], x_s[0], rnd_tt[0]);
    f_in_s[1] = fval(fsel[1], x_s[1], rnd_tt[1]);
  end

  task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s u%0d t=%0t got %h want %h", nm, k, $time, act, exp);
    end
  endtask

  // Timeline model: n counts cycles since the accepting edge.
  bit       act   [2];
  int       n     [2];
  tt_t      m_tt  [2];
  tt_t      m_exp [2];
  tt_t      h_tt  [2];
  count_t   h_ones[2];
  minterm_t h_x   [2];
  logic     h_match[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_s[k]) begin
        act[k] = 1'b0; n[k] = 0;
        h_tt[k] = '0; h_ones[k] = '0; h_x[k] = '0; h_match[k] = 1'b0;
      end else if (act[k]) begin
        n[k]++;
        if (n[k] == sweep_cycles(settle_of(k))) begin
          h_tt[k]    = m_tt[k];
          h_ones[k]  = count_t'($countones(m_tt[k]));
          h_x[k]     = minterm_t'(TT_W - 1);
          h_match[k] = (m_tt[k] == m_exp[k]);
        end
        if (n[k] > sweep_cycles(settle_of(k))) begin
          act[k] = 1'b0; n[k] = 0;
        end
      end else if (start_s[k]) begin
        act[k]    = 1'b1; n[k] = 1;
        m_exp[k]  = exp_s[k];
        m_tt[k]   = model_tt(fsel[k], rnd_tt[k]);
        h_tt[k]   = '0;
        h_ones[k] = '0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int  q;
      int  ns;
      int  lat;
      tt_t mask;
      tt_t part;
      if (act[k]) begin
        lat = sweep_cycles(settle_of(k));
        q   = (n[k] - 1) / (settle_of(k) + 1);
        ns  = (q > TT_W) ? TT_W : q;
        mask = (ns >= TT_W) ? '1 : ((tt_t'(1) << ns) - tt_t'(1));
        part = m_tt[k] & mask;
        chk("busy", k, 128'(busy_s[k]), 128'(n[k] < lat));
        chk("done", k, 128'(done_s[k]), 128'(n[k] == lat));
        chk("x_out", k, 128'(x_s[k]), 128'((q > TT_W - 1) ? TT_W - 1 : q));
        chk("tt_partial", k, tt_s[k], part);
        chk("ones_partial", k, 128'(ones_s[k]), 128'($countones(part)));
        if (n[k] == lat) chk("match", k, 128'(match_s[k]), 128'(h_match[k]));
      end else begin
        chk("busy_idle", k, 128'(busy_s[k]), 128'(0));
        chk("done_idle", k, 128'(done_s[k]), 128'(0));
        chk("x_hold", k, 128'(x_s[k]), 128'(h_x[k]));
        chk("tt_hold", k, tt_s[k], h_tt[k]);
        chk("ones_hold", k, 128'(ones_s[k]), 128'(h_ones[k]));
        chk("match_hold", k, 128'(match_s[k]), 128'(h_match[k]));
      end
    end
  end

  task automatic run_sweep(input int k, input int sel, input tt_t e, output int cyc);
    @(posedge clk); #1;
    fsel[k] = sel; exp_s[k] = e; start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    cyc = 1;
    while (done_s[k] !== 1'b1 && cyc < 1200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", k, 128'(cyc), 128'(sweep_cycles(settle_of(k))));
    $display("sweep u%0d sel=%0d cycles=%0d tt=%h ones=%0d match=%0d",
             k, sel, cyc, tt_s[k], ones_s[k], match_s[k]);
  endtask

  tt_t a_tbl;
  tt_t e_tbl;
  int  cyc;
  int  dones;
  int  first_done;
  int  sel;
  int  k;

  initial begin
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    exp_s[0] = '0; exp_s[1] = '0;
    fsel[0] = 0; fsel[1] = 0;
    rnd_tt[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    rnd_tt[1] = {$urandom(), $urandom(), $urandom(), $urandom()};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tt", 0, tt_s[0], 128'(0));
    chk("rst_ones", 0, 128'(ones_s[0]), 128'(0));
    chk("rst_busy", 0, 128'(busy_s[0]), 128'(0));
    chk("rst_x", 0, 128'(x_s[0]), 128'(0));
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;

    a_tbl = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    chk("model_x0", -1, model_tt(2, '0), a_tbl);
    chk("model_x6", -1, model_tt(3, '0), 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);
    chk("model_maj", -1, model_tt(4, '0), {16{8'hE8}});

    run_sweep(0, 0, '0, cyc);
    chk("f0_tt", 0, tt_s[0], 128'(0));
    chk("f0_ones", 0, 128'(ones_s[0]), 128'(0));
    chk("f0_match", 0, 128'(match_s[0]), 128'(1));

    run_sweep(0, 2, a_tbl, cyc);
    chk("x0_match", 0, 128'(match_s[0]), 128'(1));
    chk("x0_ones", 0, 128'(ones_s[0]), 128'(64));
    run_sweep(0, 2, a_tbl ^ (tt_t'(1) << 5), cyc);
    chk("x0_flip_match", 0, 128'(match_s[0]), 128'(0));

    run_sweep(0, 3, '0, cyc);
    chk("x6_tt", 0, tt_s[0], 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);
    chk("x6_ones", 0, 128'(ones_s[0]), 128'(64));
    run_sweep(0, 4, '0, cyc);
    chk("maj_tt", 0, tt_s[0], {16{8'hE8}});
    chk("maj_ones", 0, 128'(ones_s[0]), 128'(64));

    run_sweep(1, 1, '1, cyc);
    chk("settle_lat", 1, 128'(cyc), 128'(514));
    chk("settle_tt", 1, tt_s[1], {128{1'b1}});
    chk("settle_ones", 1, 128'(ones_s[1]), 128'(128));

    // Extra start pulses mid-sweep.
    @(posedge clk); #1;
    fsel[0] = 4; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0; cyc = 1; dones = 0; first_done = 0;
    while (cyc < 200) begin
      start_s[0] = (cyc == 10 || cyc == 60);
      @(posedge clk); #1;
      cyc++;
      if (done_s[0] === 1'b1) begin
        dones++;
        if (first_done == 0) first_done = cyc;
      end
    end
    start_s[0] = 1'b0;
    chk("ign_dones", 0, 128'(dones), 128'(1));
    chk("ign_lat", 0, 128'(first_done), 128'(130));
    $display("ignore-start u0 dones=%0d at=%0d", dones, first_done);

    // Reset in the middle of a sweep.
    rnd_tt[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk); #1;
    fsel[0] = 5; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    chk("mrst_tt", 0, tt_s[0], 128'(0));
    chk("mrst_ones", 0, 128'(ones_s[0]), 128'(0));
    chk("mrst_x", 0, 128'(x_s[0]), 128'(0));
    chk("mrst_busy", 0, 128'(busy_s[0]), 128'(0));
    $display("mid-sweep reset u0 applied");
    run_sweep(0, 5, rnd_tt[0], cyc);
    chk("post_rst_tt", 0, tt_s[0], rnd_tt[0]);
    chk("post_rst_ones", 0, 128'(ones_s[0]), 128'($countones(rnd_tt[0])));
    chk("post_rst_match", 0, 128'(match_s[0]), 128'(1));

    // Start in DONE is dropped; start in the following IDLE cycle is taken.
    run_sweep(0, 2, '0, cyc);
    start_s[0] = 1'b1; exp_s[0] = a_tbl;
    @(posedge clk); #1;
    chk("done_start_busy", 0, 128'(busy_s[0]), 128'(0));
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    chk("idle_start_busy", 0, 128'(busy_s[0]), 128'(1));
    cyc = 1;
    while (done_s[0] !== 1'b1 && cyc < 1200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_lat", 0, 128'(cyc), 128'(130));
    chk("b2b_match", 0, 128'(match_s[0]), 128'(1));
    $display("back-to-back u0 cycles=%0d match=%0d", cyc, match_s[0]);

    for (int r = 0; r < 8; r++) begin
      k   = (r % 4 == 3) ? 1 : 0;
      sel = $urandom_range(0, 5);
      rnd_tt[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      e_tbl = ($urandom_range(0, 1) == 1) ? model_tt(sel, rnd_tt[k])
                                          : {$urandom(), $urandom(), $urandom(), $urandom()};
      run_sweep(k, sel, e_tbl, cyc);
      chk("rand_tt", k, tt_s[k], model_tt(sel, rnd_tt[k]));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Truth-table extractor for the 7-input function library. It is the reading end of each synthesized majority-gate function.
- On start, drives all 128 input minterms into a combinational device-under-test (DUT) and samples its single output. It then assembles the 128-bit truth table in the same hex ordering used to name each function.
- Compares the captured table with an expected table, reports match and onset count. Used in the on-chip self-check harness around each generated function module.

Parameters:
- N_IN, 7, number of DUT inputs; TT_W = 2**N_IN is derived.
- SETTLE, 0, extra wait cycles per minterm before sampling f_in (range 0..15).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to begin a sweep
- expected_tt  input  TT_W  reference truth table; sampled on accepted start
- f_in  input  1  DUT output, combinational function of x_out
- x_out  output  N_IN  DUT inputs; x_out[0] drives x0
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when results are valid
- tt_out  output  TT_W  captured table; bit i = f(x_out == i)
- match  output  1  tt_out == expected table; valid from done onward
- ones_count  output  N_IN+1  popcount of tt_out (0..128)

Behaviour:
- Reset: state IDLE; x_out=0, busy=0, done=0, tt_out=0, match=0, ones_count=0; internal expected register=0.
- IDLE: start=1 is accepted. Latch expected_tt, clear tt_out and ones_count, set idx=0, wait=0, go to SWEEP. busy=1 from the next cycle.
- SWEEP: x_out = idx (registered).
  - While wait < SETTLE, increment wait.
  - When wait == SETTLE: tt_out[idx] <= f_in; ones_count += f_in; wait <= 0.
  - If idx == TT_W-1, go to CHECK; otherwise idx++.
- CHECK (1 cycle): match <= (tt_out == expected); go to DONE.
- DONE (1 cycle): done=1, busy=0; return to IDLE.
- Latency: accepted start edge to done high = TT_W*(SETTLE+1) + 2 cycles. For SETTLE=0 this is 130.
- After done, x_out, tt_out, match and ones_count hold until the next accepted start.
- start while busy: ignored; it does not restart or extend the sweep.
- start in the DONE cycle: ignored. start in the IDLE cycle immediately after DONE: accepted.
- rst mid-sweep (any state): full return to reset values next edge; the partial table is discarded.
- idx has width N_IN. The wrap to 0 never occurs inside a sweep, because termination is on idx == TT_W-1.
- Hex view: tt_out[TT_W-1:TT_W-4] is the first hex character of the function's name string.
- No combinational path from f_in to any output.

Decomposition:
- Shared package tt_pkg:
  - N_IN and TT_W constants.
  - State enum {IDLE, SWEEP, CHECK, DONE}.
  - Width typedefs: tt_t (TT_W bits), minterm_t (N_IN bits), count_t (N_IN+1 bits).
- One natural sub-module: tt_sweep_ctrl, holding the FSM plus the idx/wait counters. It emits sample_en and last, and the datapath (table shift-in, popcount, compare) stays in the top.

Test Plan:
- DUT f=0, expected=0, SETTLE=0 -> done exactly 130 cycles after start; tt_out=0, ones_count=0, match=1.
- DUT f=x0, expected=0xAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA -> match=1, ones_count=64. Flip expected bit 5 -> match=0.
- DUT f=x6 -> tt_out=0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, ones_count=64. DUT f=maj(x0,x1,x2) -> tt_out=0xE8 repeated 16 times, ones_count=64.
- SETTLE=3, DUT f=1 -> each x_out value held 4 cycles; done at cycle 514; tt_out all ones, ones_count=128.
- Pulse start at cycles 10 and 60 of a sweep -> ignored; exactly one done, no change in latency.
- Assert rst at sweep cycle 70 -> next cycle all outputs zero, state IDLE. A new start then gives a clean full result with no residue.
